instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 155 +++++++++++++++
 tb/tb_instr_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches words from a loadable instruction memory and
// issues the register triple of each add instruction over a valid/ready handshake.
module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          start,
  output logic [4:0]    srcReg1,
  output logic [4:0]    srcReg2,
  output logic [4:0]    destReg,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [7:0]    issue_count,
  output logic [7:0]    skip_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_PC   = AW'(DEPTH - 1);
  localparam logic [5:0]    OP_HALT   = 6'h3F;
  localparam logic [5:0]    FUNCT_ADD = 6'h20;

  logic [31:0]   mem [DEPTH];
  state_t        state, state_next;
  logic [31:0]   ir, ir_next;
  logic [AW-1:0] pc_next;
  logic [7:0]    issue_count_next, skip_count_next;
  logic          issue_valid_next;
  logic [4:0]    src1_next, src2_next, dest_next;
  logic [31:0]   fetch_word;
  logic          loadable;

  assign loadable   = (state == IDLE) || (state == DONE);
  assign fetch_word = mem[pc];
  assign busy       = (state == FETCH) || (state == ISSUE);
  assign done       = (state == DONE);

  // Memory has no reset so its contents survive both rst_n and start.
  always_ff @(posedge clk) begin
    if (load_en && loadable)
      mem[load_addr] <= load_data;
  end

  function automatic logic is_add(input logic [31:0] w);
    return (w[31:26] == 6'd0) && (w[5:0] == FUNCT_ADD);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ir          <= '0;
      pc          <= '0;
      issue_count <= '0;
      skip_count  <= '0;
      issue_valid <= 1'b0;
      srcReg1     <= '0;
      srcReg2     <= '0;
      destReg     <= '0;
    end else begin
      state       <= state_next;
      ir          <= ir_next;
      pc          <= pc_next;
      issue_count <= issue_count_next;
      skip_count  <= skip_count_next;
      issue_valid <= issue_valid_next;
      srcReg1     <= src1_next;
      srcReg2     <= src2_next;
      destReg     <= dest_next;
    end
  end

  always_comb begin
    state_next       = state;
    ir_next          = ir;
    pc_next          = pc;
    issue_count_next = issue_count;
    skip_count_next  = skip_count;
    issue_valid_next = issue_valid;
    src1_next        = srcReg1;
    src2_next        = srcReg2;
    dest_next        = destReg;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next       = FETCH;
          pc_next          = '0;
          issue_count_next = '0;
          skip_count_next  = '0;
        end
      end

      FETCH: begin
        // Decoding the add here lets issue_valid be a plain register that is
        // already high in the first ISSUE cycle.
        ir_next    = fetch_word;
        state_next = ISSUE;
        if (is_add(fetch_word)) begin
          issue_valid_next = 1'b1;
          src1_next        = fetch_word[25:21];
          src2_next        = fetch_word[20:16];
          dest_next        = fetch_word[15:11];
        end
      end

      ISSUE: begin
        if (issue_valid) begin
          if (issue_ready) begin
            issue_valid_next = 1'b0;
            src1_next        = '0;
            src2_next        = '0;
            dest_next        = '0;
            issue_count_next = sat_inc(issue_count);
            if (pc == LAST_PC) begin
              state_next = DONE;
            end else begin
              pc_next    = pc + AW'(1);
              state_next = FETCH;
            end
          end
        end else if (ir[31:26] == OP_HALT) begin
          state_next = DONE;
        end else begin
          skip_count_next = sat_inc(skip_count);
          if (pc == LAST_PC) begin
            state_next = DONE;
          end else begin
            pc_next    = pc + AW'(1);
            state_next = FETCH;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed programs plus randomized
// programs and ready patterns, checked against a program-level reference model.
module tb_instr_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic          clk;
  logic          rst_n;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          start;
  logic [4:0]    srcReg1, srcReg2, destReg;
  logic          issue_valid;
  logic          issue_ready;
  logic [AW-1:0] pc;
  logic          busy, done;
  logic [7:0]    issue_count, skip_count;

  int vectors;
  int miscompares;
  logic [31:0] model_mem [DEPTH];

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .srcReg1     (srcReg1),
    .srcReg2     (srcReg2),
    .destReg     (destReg),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .issue_count (issue_count),
    .skip_count  (skip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h00, 6'h20};
  endfunction

  // Called at a negedge; the write lands on the following posedge.
  task automatic load_word(input int a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic run_and_check(input string name, input int stall_first, input bit rnd_ready,
                               input bit check_rate, input bit busy_write,
                               input bit load_with_start, input logic [31:0] start_word);
    logic [14:0] exp_q[$];
    logic [14:0] got, want, held;
    logic [AW-1:0] held_pc;
    logic [31:0] w;
    int exp_iss, exp_skip, exp_pc, stall_left, cyc, last_xfer;
    bit first_seen;

    if (load_with_start) begin
      load_en = 1'b1; load_addr = '0; load_data = start_word;
      model_mem[0] = start_word;
    end

    // Reference model: walk the program from address 0 by the instruction rules.
    exp_iss = 0; exp_skip = 0; exp_pc = DEPTH - 1;
    for (int p = 0; p < DEPTH; p++) begin
      w = model_mem[p];
      if (w[31:26] == 6'h3F) begin
        exp_pc = p;
        break;
      end else if (w[31:26] == 6'h00 && w[5:0] == 6'h20) begin
        exp_q.push_back(w[25:11]);
        if (exp_iss < 255) exp_iss++;
      end else begin
        if (exp_skip < 255) exp_skip++;
      end
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    end

    stall_left = stall_first; cyc = 0; last_xfer = -1; first_seen = 0; held = '0; held_pc = '0;
    while (done !== 1'b1 && cyc < 400) begin
      if (busy_write) begin
        load_en = 1'b1; load_addr = AW'(1); load_data = enc_add(5'd10, 5'd11, 5'd12);
      end
      if (issue_valid === 1'b1) begin
        got = {srcReg1, srcReg2, destReg};
        if (!first_seen) begin
          first_seen = 1; held = got; held_pc = pc;
        end
        if (stall_left > 0) begin
          issue_ready = 1'b0;
          stall_left--;
          vectors++;
          if (got !== held || pc !== held_pc) begin
            miscompares++;
            $display("FAIL %s stall_hold: got %h pc %0d expected %h pc %0d", name, got, pc, held, held_pc);
          end
        end else begin
          issue_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (issue_ready) begin
          want = (exp_q.size() > 0) ? exp_q.pop_front() : 15'h7FFF;
          vectors++;
          if (got !== want) begin
            miscompares++;
            $display("FAIL %s issue_triple: got %h expected %h", name, got, want);
          end else begin
            $display("[%s] issue rs=%0d rt=%0d rd=%0d pc=%0d cycle=%0d", name, srcReg1, srcReg2, destReg, pc, cyc);
          end
          if (check_rate && last_xfer >= 0) begin
            vectors++;
            if (cyc - last_xfer != 2) begin
              miscompares++;
              $display("FAIL %s issue_spacing: got %0d cycles expected 2", name, cyc - last_xfer);
            end
          end
          last_xfer = cyc;
        end
      end else begin
        issue_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        vectors++;
        if ({srcReg1, srcReg2, destReg} !== 15'd0) begin
          miscompares++;
          $display("FAIL %s idle_regs_zero: got %h expected 0", name, {srcReg1, srcReg2, destReg});
        end
      end
      @(negedge clk);
      cyc++;
    end
    load_en = 1'b0;
    issue_ready = 1'b0;

    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done_timeout: done %b after %0d cycles expected 1", name, done, cyc);
    end
    vectors++;
    if (issue_count !== 8'(exp_iss) || skip_count !== 8'(exp_skip)) begin
      miscompares++;
      $display("FAIL %s counts: got issue %0d skip %0d expected issue %0d skip %0d",
               name, issue_count, skip_count, exp_iss, exp_skip);
    end
    vectors++;
    if (pc !== AW'(exp_pc) || busy !== 1'b0 || issue_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s final_state: got pc %0d busy %b valid %b expected pc %0d busy 0 valid 0",
               name, pc, busy, issue_valid, exp_pc);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s missing_issues: got %0d outstanding expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (issue_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pc !== '0 ||
        issue_count !== 8'd0 || skip_count !== 8'd0 || {srcReg1, srcReg2, destReg} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_values: got valid %b busy %b done %b pc %0d ic %0d sc %0d regs %h expected all 0",
               issue_valid, busy, done, pc, issue_count, skip_count, {srcReg1, srcReg2, destReg});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stays_idle: got busy %b done %b expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    load_word(0, enc_add(5'd1, 5'd2, 5'd3));
    load_word(1, HALT);
    run_and_check("basic", 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic test_stall();
    run_and_check("stall", 5, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic test_skip();
    load_word(0, 32'h8C01_0000);
    load_word(1, enc_add(5'd4, 5'd5, 5'd6));
    load_word(2, HALT);
    run_and_check("skip", 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++)
      load_word(i, enc_add(5'(i), 5'(i + 1), 5'(31 - i)));
    run_and_check("full", 0, 0, 1, 0, 0, 32'h0);
  endtask

  task automatic test_async_reset();
    int waited;
    load_word(0, enc_add(5'd1, 5'd2, 5'd3));
    load_word(1, HALT);
    issue_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (issue_valid !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (issue_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_setup: got valid %b expected 1", issue_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (issue_valid !== 1'b0 || {srcReg1, srcReg2, destReg} !== 15'd0 || busy !== 1'b0 ||
        issue_count !== 8'd0 || skip_count !== 8'd0 || pc !== '0) begin
      miscompares++;
      $display("FAIL areset_immediate: got valid %b regs %h busy %b ic %0d sc %0d pc %0d expected all 0",
               issue_valid, {srcReg1, srcReg2, destReg}, busy, issue_count, skip_count, pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_and_check("after_reset", 0, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic test_load_busy();
    load_word(0, enc_add(5'd1, 5'd2, 5'd3));
    load_word(1, enc_add(5'd7, 5'd8, 5'd9));
    load_word(2, HALT);
    run_and_check("load_busy", 0, 0, 0, 1, 0, 32'h0);
  endtask

  task automatic test_start_load();
    run_and_check("start_load", 0, 0, 0, 0, 1, enc_add(5'd13, 5'd14, 5'd15));
  endtask

  task automatic test_random();
    logic [31:0] w;
    int r;
    for (int it = 0; it < 5; it++) begin
      for (int p = 0; p < DEPTH; p++) begin
        r = $urandom_range(0, 9);
        if (r < 5)       w = enc_add(5'($urandom), 5'($urandom), 5'($urandom));
        else if (r == 5) w = HALT;
        else             w = $urandom();
        load_word(p, w);
      end
      run_and_check("random", int'($urandom_range(0, 3)), 1, 0, 0, 0, 32'h0);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; issue_ready = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

    test_reset();
    // Give every entry a known value so the model matches the (unreset) memory.
    for (int i = 0; i < DEPTH; i++) load_word(i, HALT);
    test_basic();
    test_stall();
    test_skip();
    test_back_to_back();
    test_async_reset();
    test_load_busy();
    test_start_load();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
